// File: rtl/ook_demod_pkg.sv
// ook_demod_pkg: shared FSM state type and default-geometry constants for ook_demod.
// CHECK exists only when OOK_DEMOD_PARITY_EN is defined.
package ook_demod_pkg;
    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        PAYLOAD,
`ifdef OOK_DEMOD_PARITY_EN
        CHECK,
`endif
        DONE
    } state_e;
    localparam int PRE_W    = 8;
    localparam int LOG2_SPS = $clog2(16);
    localparam int ACC_W    = 16 + 1 + LOG2_SPS;
endpackage

// File: rtl/ook_demod_iq_mag.sv
// iq_mag: saturating |I|,|Q| and alpha-max/beta-min magnitude, registered one cycle
// after the input strobe together with a matching valid.
module iq_mag #(
    parameter int NIN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic signed [NIN-1:0] i_i,
    input  logic signed [NIN-1:0] q_i,
    output logic [NIN:0]          mag_o,
    output logic                  mag_valid_o
);
    logic [NIN-1:0] a, b, mx, mn;
    logic [NIN:0]   mag_d, mag_q;
    logic           valid_q;

    function automatic logic [NIN-1:0] sat_abs(input logic [NIN-1:0] x);
        return (x == {1'b1, {(NIN-1){1'b0}}}) ? {1'b0, {(NIN-1){1'b1}}} :
               (x[NIN-1] ? ~x + 1'b1 : x);
    endfunction

    assign a     = sat_abs(i_i);
    assign b     = sat_abs(q_i);
    assign mx    = (a > b) ? a : b;
    assign mn    = (a > b) ? b : a;
    assign mag_d = {1'b0, mx} + {2'b00, mn[NIN-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid_i;
            if (in_valid_i) mag_q <= mag_d;
        end
    end

    assign mag_o       = mag_q;
    assign mag_valid_o = valid_q;
endmodule

// File: rtl/ook_demod.sv
// ook_demod: OOK symbol slicer plus preamble-hunting frame FSM.
// Define OOK_DEMOD_PARITY_EN to append and check an even-parity bit after the payload.
module ook_demod
    import ook_demod_pkg::*;
#(
    parameter int           NIN      = 16,
    parameter int           SPS      = 16,
    parameter logic [7:0]   PREAMBLE = 8'hA5,
    parameter int           PAY_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic signed [NIN-1:0] I_in,
    input  logic signed [NIN-1:0] Q_in,
    input  logic [NIN-1:0]        thresh,
    output logic                  sym_valid,
    output logic                  sym_bit,
    output logic                  frame_valid,
    output logic [7:0]            frame_data,
    output logic                  locked,
    output logic                  parity_err
);
    localparam int LSPS = $clog2(SPS);
    localparam int AW   = NIN + 1 + LSPS;
`ifdef OOK_DEMOD_PARITY_EN
    localparam int PW   = PAY_BITS + 1;
`else
    localparam int PW   = PAY_BITS;
`endif

    logic [NIN:0]      mag;
    logic              mag_valid;
    state_e            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d, sum;
    logic [LSPS-1:0]   cnt_q, cnt_d;
    logic              below_q, below_d, above, active;
    logic              sym_valid_q, sym_valid_d, sym_bit_q, sym_bit_d;
    logic [PRE_W-1:0]  sr_q, sr_d, sr_n;
    logic [PW-1:0]     pay_q, pay_d, pay_n;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [7:0]        frame_data_q, frame_data_d;

    iq_mag #(.NIN(NIN)) u_mag (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .i_i        (I_in),
        .q_i        (Q_in),
        .mag_o      (mag),
        .mag_valid_o(mag_valid)
    );

    assign sum    = acc_q + AW'(mag);
    assign above  = mag >= {1'b0, thresh};
    assign active = (state_q == HUNT) || (state_q == PAYLOAD);
    assign sr_n   = PRE_W'({sr_q, sym_bit_q});
    assign pay_n  = PW'({pay_q, sym_bit_q});

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        below_d      = below_q;
        sym_valid_d  = 1'b0;
        sym_bit_d    = 1'b0;
        sr_d         = sr_q;
        pay_d        = pay_q;
        bcnt_d       = bcnt_q;
        frame_data_d = frame_data_q;
        if (active && mag_valid) begin
            below_d = !above;
            // a low-to-high crossing while hunting restarts the symbol on this sample
            if (state_q == HUNT && above && below_q) begin
                acc_d = AW'(mag);
                cnt_d = LSPS'(1);
            end else if (&cnt_q) begin
                acc_d       = '0;
                cnt_d       = '0;
                sym_valid_d = 1'b1;
                sym_bit_d   = (sum >> LSPS) >= AW'(thresh);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                acc_d   = '0;
                cnt_d   = '0;
                below_d = 1'b0;
                sr_d    = '0;
                pay_d   = '0;
                bcnt_d  = '0;
                state_d = en ? HUNT : IDLE;
            end
            HUNT: if (sym_valid_q) begin
                sr_d = sr_n;
                if (sr_n == PREAMBLE) begin
                    state_d = PAYLOAD;
                    sr_d    = '0;
                    pay_d   = '0;
                    bcnt_d  = '0;
                end
            end
            PAYLOAD: if (sym_valid_q) begin
                pay_d  = pay_n;
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == 4'(PW - 1)) begin
`ifdef OOK_DEMOD_PARITY_EN
                    state_d = CHECK;
`else
                    state_d      = DONE;
                    frame_data_d = 8'(pay_n);
`endif
                end
            end
`ifdef OOK_DEMOD_PARITY_EN
            CHECK: begin
                state_d      = (~^pay_q) ? DONE : HUNT;
                frame_data_d = (~^pay_q) ? 8'(pay_q >> 1) : frame_data_q;
            end
`endif
            DONE: begin
                sr_d    = '0;
                state_d = HUNT;
            end
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            below_q      <= 1'b0;
            sym_valid_q  <= 1'b0;
            sym_bit_q    <= 1'b0;
            sr_q         <= '0;
            pay_q        <= '0;
            bcnt_q       <= '0;
            frame_data_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            below_q      <= below_d;
            sym_valid_q  <= sym_valid_d;
            sym_bit_q    <= sym_bit_d;
            sr_q         <= sr_d;
            pay_q        <= pay_d;
            bcnt_q       <= bcnt_d;
            frame_data_q <= frame_data_d;
        end
    end

    assign sym_valid   = sym_valid_q;
    assign sym_bit     = sym_bit_q;
    assign frame_valid = state_q == DONE;
    assign frame_data  = frame_data_q;
    assign locked      = state_q == PAYLOAD;
`ifdef OOK_DEMOD_PARITY_EN
    assign parity_err  = (state_q == CHECK) && ^pay_q;
`else
    assign parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_ook_demod.sv
// tb_ook_demod: directed table-driven bench for ook_demod (default build, parity disabled).
module tb_ook_demod;
    import ook_demod_pkg::*;

    logic               clk = 1'b0;
    logic               rst, en, in_valid;
    logic signed [15:0] I_in, Q_in;
    logic [15:0]        thresh;
    logic               sym_valid, sym_bit, frame_valid, locked, parity_err;
    logic [7:0]         frame_data;

    int n_chk  = 0;
    int n_fail = 0;
    int fv_cnt = 0;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic [16:0]        mag;
    } mag_vec_t;

    typedef struct {
        logic signed [15:0] i;
        int                 n;
        int                 nsv;
        int                 idx;
        logic               bitv;
    } sl_vec_t;

    mag_vec_t mv[8];
    sl_vec_t  st[4];

    ook_demod dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .I_in       (I_in),
        .Q_in       (Q_in),
        .thresh     (thresh),
        .sym_valid  (sym_valid),
        .sym_bit    (sym_bit),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .locked     (locked),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // one sample every 20 cycles; observes mag at t+1, sym at t+2, frame/lock at t+3
    task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                        output logic sv, output logic b, output logic lk, output logic fv,
                        output logic [16:0] m, output logic [7:0] fd);
        I_in = i; Q_in = q; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        m = dut.mag;
        @(posedge clk); #1;
        sv = sym_valid; b = sym_bit;
        @(posedge clk); #1;
        lk = locked; fv = frame_valid; fd = frame_data;
        repeat (17) @(posedge clk);
        #1;
    endtask

    task automatic send_n(input logic signed [15:0] i, input int n,
                          output int nsv, output int idx, output logic lb);
        logic sv, b, lk, fv;
        logic [16:0] m;
        logic [7:0] fd;
        nsv = 0; idx = -1; lb = 1'b0;
        for (int k = 0; k < n; k++) begin
            send(i, 16'sd0, sv, b, lk, fv, m, fd);
            if (sv) begin nsv++; idx = k; lb = b; end
        end
    endtask

    task automatic send_sym(input logic bitv, output logic sv, output logic b,
                            output logic lk, output logic fv, output logic [7:0] fd);
        logic [16:0] m;
        for (int k = 0; k < 16; k++) send(bitv ? 16'sd2000 : 16'sd0, 16'sd0, sv, b, lk, fv, m, fd);
    endtask

    task automatic send_byte(input logic [7:0] v, input int n, output logic lk_last);
        logic sv, b, fv;
        logic [7:0] fd;
        lk_last = 1'b0;
        for (int k = 0; k < n; k++) send_sym(v[7-k], sv, b, lk_last, fv, fd);
    endtask

    initial begin
        logic sv, b, lk, fv, lb;
        logic [16:0] m;
        logic [7:0] fd, pay;
        logic [9:0] pre;
        int nsv, idx, fv0;

        mv[0] = '{16'sd3000,   -16'sd4000,  17'd5500};
        mv[1] = '{-16'sd32768, 16'sd0,      17'd32767};
        mv[2] = '{16'sd0,      16'sd0,      17'd0};
        mv[3] = '{-16'sd1,     -16'sd1,     17'd1};
        mv[4] = '{16'sd100,    -16'sd100,   17'd150};
        mv[5] = '{-16'sd32768, -16'sd32768, 17'd49150};
        mv[6] = '{16'sd32767,  16'sd1,      17'd32767};
        mv[7] = '{-16'sd7,     16'sd20,     17'd23};
        st[0] = '{16'sd1000, 16, 1, 15, 1'b1};
        st[1] = '{16'sd999,  16, 1, 15, 1'b0};
        st[2] = '{16'sd999,  5,  0, -1, 1'b0};
        st[3] = '{16'sd1000, 16, 1, 15, 1'b1};

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; I_in = '0; Q_in = '0; thresh = 16'd1000;
        #1;
        check("rst_sym_valid", 32'(sym_valid), 0);
        check("rst_sym_bit", 32'(sym_bit), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_frame_data", 32'(frame_data), 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            send(mv[k].i, mv[k].q, sv, b, lk, fv, m, fd);
            check("mag", 32'(m), 32'(mv[k].mag));
        end

        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // last row follows five sub-threshold samples: crossing must realign the symbol
        for (int k = 0; k < 4; k++) begin
            send_n(st[k].i, st[k].n, nsv, idx, lb);
            check("slice_count", 32'(nsv), 32'(st[k].nsv));
            check("slice_index", 32'(idx), 32'(st[k].idx));
            if (st[k].nsv > 0) check("slice_bit", 32'(lb), 32'(st[k].bitv));
        end

        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pre = 10'b0010100101;
        for (int k = 0; k < 10; k++) begin
            send_sym(pre[9-k], sv, b, lk, fv, fd);
            check("pre_sym_valid", 32'(sv), 1);
            check("pre_bit", 32'(b), 32'(pre[9-k]));
            check("pre_locked", 32'(lk), 32'(k == 9));
        end
        pay = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            send_sym(pay[7-k], sv, b, lk, fv, fd);
            check("pay_bit", 32'(b), 32'(pay[7-k]));
            check("pay_locked", 32'(lk), 32'(k < 7));
            check("pay_frame_valid", 32'(fv), 32'(k == 7));
            if (k == 7) check("pay_frame_data", 32'(fd), 32'h3C);
        end
        check("frame_count_1", 32'(fv_cnt), 1);

        fv0 = fv_cnt;
        send_byte(8'hA5, 8, lk);
        check("abort_locked_pre", 32'(lk), 1);
        send_byte(8'hB0, 4, lk);
        check("abort_locked_mid", 32'(lk), 1);
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_locked", 32'(locked), 0);
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_frame", 32'(fv_cnt), 32'(fv0));
        check("abort_hold_data", 32'(frame_data), 32'h3C);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'hA5, 8, lk);
        check("rehunt_locked", 32'(lk), 1);
        pay = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            send_sym(pay[7-k], sv, b, lk, fv, fd);
            if (k == 7) begin
                check("rehunt_frame_valid", 32'(fv), 1);
                check("rehunt_frame_data", 32'(fd), 32'h5A);
            end
        end
        check("frame_count_2", 32'(fv_cnt), 32'(fv0 + 1));

        send_byte(8'hA5, 8, lk);
        send_byte(8'hE0, 3, lk);
        check("prereset_locked", 32'(locked), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_locked", 32'(locked), 0);
        check("midrst_frame_data", 32'(frame_data), 0);
        check("midrst_frame_valid", 32'(frame_valid), 0);
        check("midrst_sym_valid", 32'(sym_valid), 0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1 rst = 1'b0;
        fv0 = fv_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("postrst_no_frame", 32'(fv_cnt), 32'(fv0));
        check("postrst_sym_valid", 32'(sym_valid), 0);
        check("postrst_state", 32'(dut.state_q), 32'(HUNT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
